// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// default operand width.
package serial_subtractor_pkg;

  localparam int unsigned DefaultWidth = 8;

  // Fixed 2-bit encodings so the state value is stable across builds.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// fs_bit: combinational one-bit full subtractor, computing x - y - bi.
// Ports:
//   x  - minuend bit
//   y  - subtrahend bit
//   bi - borrow in
//   d  - difference bit
//   bo - borrow out
module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b (mod 2^W).
// The operation runs LSB first, one bit per clock, through a single fs_bit cell.
// A start/busy/done handshake frames each operation.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous reset, active high
//   start  - launch request, sampled only while idle
//   a, b   - minuend / subtrahend, captured on the accepting edge
//   busy   - high while the shift phase runs
//   done   - one-cycle pulse when diff/borrow become valid
//   diff   - result, held until the next accepted start
//   borrow - final borrow out (1 iff a < b unsigned)
//   ovf    - signed overflow of the subtraction (only with SERIAL_SUB_OVF_EN)
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned W = DefaultWidth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  state_e state_q, state_d;

  logic [W-1:0]    shreg_a_q;
  logic [W-1:0]    shreg_b_q;
  logic            brw_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    diff_q;
  logic            borrow_q;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic accept;
  logic last;
  logic d_bit;
  logic bo_bit;

  assign accept = (state_q == StIdle) && start;
  assign last   = (state_q == StShift) && (cnt_q == LastCnt);

  fs_bit u_fs_bit (
    .x  (shreg_a_q[0]),
    .y  (shreg_b_q[0]),
    .bi (brw_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state, registered below so outputs are flops
  always_comb begin
    busy_d = (state_d == StShift);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Datapath. shreg_a doubles as the result register: as minuend bits leave
  // at the LSB, difference bits enter at the MSB, so after W shifts it holds
  // the full result. diff is a separate holding register loaded only on the
  // last shift, so partial results never appear on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_a_q <= '0;
      shreg_b_q <= '0;
      brw_q     <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
    end else if (accept) begin
      shreg_a_q <= a;
      shreg_b_q <= b;
      brw_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (state_q == StShift) begin
      shreg_a_q <= {d_bit, shreg_a_q[W-1:1]};
      shreg_b_q <= {1'b0, shreg_b_q[W-1:1]};
      brw_q     <= bo_bit;
      cnt_q     <= cnt_q + 1'b1;
      if (last) begin
        diff_q   <= {d_bit, shreg_a_q[W-1:1]};
        borrow_q <= bo_bit;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are kept aside because shreg_a/shreg_b are consumed.
  logic a_sign_q;
  logic b_sign_q;
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_sign_q <= a[W-1];
      b_sign_q <= b[W-1];
    end else if (last) begin
      // d_bit is the result MSB on the last shift
      ovf_q <= (a_sign_q != b_sign_q) && (d_bit != a_sign_q);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
